// File: rtl/imm_gen_pipe.sv
// Registered immediate-generation stage: decodes RISC-V immediates from an instruction
// word and hands them to execute through a 2-entry in-order skid buffer.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef enum logic [2:0] {
    SRC_I  = 3'b000,
    SRC_S  = 3'b001,
    SRC_B  = 3'b010,
    SRC_J  = 3'b011,
    SRC_U  = 3'b100,
    SRC_Z  = 3'b101,
    SRC_SH = 3'b110,
    SRC_X  = 3'b111
  } imm_src_e;

  logic [63:0]      imm_wide;
  logic [XLEN-1:0]  imm_c;
  logic             err_c;
  logic             sgn;

  assign sgn = in_instr[31];

  // Everything is built at 64 bits and truncated, so one code path serves both widths.
  always_comb begin
    imm_wide = '0;
    err_c    = 1'b0;
    case (imm_src_e'(in_imm_src))
      SRC_I:  imm_wide = {{52{sgn}}, in_instr[31:20]};
      SRC_S:  imm_wide = {{52{sgn}}, in_instr[31:25], in_instr[11:7]};
      SRC_B:  imm_wide = {{52{sgn}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      SRC_J:  imm_wide = {{44{sgn}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      SRC_U:  imm_wide = {{32{sgn}}, in_instr[31:12], 12'b0};
      SRC_Z:  imm_wide = {59'b0, in_instr[19:15]};
      SRC_SH: begin
        if (XLEN == 64) imm_wide = {58'b0, in_instr[25:20]};
        else            imm_wide = {59'b0, in_instr[24:20]};
      end
      default: begin
        imm_wide = '0;
        err_c    = 1'b1;
      end
    endcase
  end

  assign imm_c = imm_wide[XLEN-1:0];

  logic [XLEN-1:0]  mem_imm [2];
  logic [TAG_W-1:0] mem_tag [2];
  logic [1:0]       mem_err;
  logic             head;
  logic             tail;
  logic [1:0]       count;
  logic [1:0]       count_next;
  logic             push;
  logic             pop;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && in_ready && !flush;
  assign tail      = head ^ count[0];

  assign out_imm = mem_imm[head];
  assign out_err = mem_err[head];
  assign out_tag = mem_tag[head];

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + 2'd1;
        2'b01:   count_next = count - 2'd1;
        default: count_next = count;
      endcase
    end
  end

  // in_ready comes from a flop so upstream never sees a combinational path from out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= 2'd0;
      head       <= 1'b0;
      in_ready   <= 1'b0;
      mem_imm[0] <= '0;
      mem_imm[1] <= '0;
      mem_tag[0] <= '0;
      mem_tag[1] <= '0;
      mem_err    <= '0;
    end else begin
      count    <= count_next;
      in_ready <= (count_next != 2'd2);
      if (pop) head <= ~head;
      if (push) begin
        mem_imm[tail] <= imm_c;
        mem_tag[tail] <= in_tag;
        mem_err[tail] <= err_c;
      end
    end
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, handshaked immediate-generation stage for the decode pipeline.
- Takes a 32-bit instruction word plus a 3-bit format select, and produces a sign- or zero-extended immediate of width XLEN.
- Adds formats for CSR zimm and shift amounts, and an illegal-select flag.
- A 2-entry skid buffer between decode and execute absorbs backpressure without a combinational ready path.

Parameters:
- XLEN, 32, output immediate width; legal values are 32 or 64.
- TAG_W, 8, width of the sideband tag (e.g. rd/ROB index) carried alongside each immediate.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous; discards all buffered entries.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  stage can accept this cycle; registered.
- in_instr  input  32  instruction word.
- in_imm_src  input  3  format select.
- in_tag  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  out_imm/out_err/out_tag are valid.
- out_ready  input  1  downstream accepts.
- out_imm  output  XLEN  extended immediate.
- out_err  output  1  in_imm_src was 3'b111.
- out_tag  output  TAG_W  tag of the presented entry.

Behaviour:
- Format encodings (s = sign-extend bit instr[31] to XLEN):
  - 000 I: s, instr[31:20].
  - 001 S: s, instr[31:25], instr[11:7].
  - 010 B: s, instr[7], instr[30:25], instr[11:8], 0.
  - 011 J: s, instr[19:12], instr[20], instr[30:21], 0.
  - 100 U: instr[31:12] followed by 12 zeros, then sign-extended from bit 31 to XLEN.
  - 101 Z: zero-extended instr[19:15].
  - 110 SH: zero-extended instr[25:20] when XLEN=64; zero-extended instr[24:20] when XLEN=32.
  - 111: imm=0, err=1.
  - err=0 for every format except 111.
- Immediate is computed combinationally from in_* and captured on acceptance.
- Latency: accept on cycle N (in_valid && in_ready) -> out_valid=1 in cycle N+1, provided no older entry is pending.
- Buffer: 2-entry FIFO, strictly in order. Storage is data + err + tag per entry. An occupancy counter 0..2 is held, plus a head pointer.
- Output side: out_* present the head entry, out_valid = (count != 0). Pop when out_valid && out_ready.
- Input side: in_ready = (count < 2), registered from next-state count.
  - Push and pop in the same cycle at count=2 is not possible, because in_ready=0.
  - At count=1, simultaneous push and pop leaves count=1 and advances the head.
- Stability: while out_valid && !out_ready, out_imm/out_err/out_tag must not change.
- Empty: out_imm/out_err/out_tag are held at their last value (0 after reset). The bench must not check them while out_valid=0.
- flush=1: count <- 0 and out_valid <- 0 next cycle. An in_valid arriving in the same cycle is dropped (not pushed), regardless of in_ready. in_ready=1 next cycle.
- Reset asserted (async, any time, including mid-transfer):
  - out_valid=0, in_ready=0, out_imm=0, out_err=0, out_tag=0, count=0, head=0.
  - First cycle after deassertion: in_ready=1.
- in_imm_src X/undefined values are not legal; all 8 codes are defined.
- Parameter check: XLEN not in {32,64} is an elaboration error.

Test Plan:
- XLEN=32, I-type, in_instr=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> one cycle later out_valid=1, out_imm=0xFFFFFFFF, out_err=0, tag echoed.
- B-type 0xFE000EE3 (beq -4) -> 0xFFFFFFFC. J-type 0x0080006F (jal +8) -> 0x00000008. S-type 0xFE112E23 (sw x1,-4(x2)) -> 0xFFFFFFFC.
- XLEN=64: U-type 0x800000B7 (lui x1,0x80000) -> 0xFFFFFFFF80000000. SH 0x03F09093 (slli x1,x1,63) -> 0x3F. Z: in_instr[19:15]=5'b11111 -> 0x1F. src=111 -> imm=0, err=1.
- Backpressure:
  - Hold out_ready=0 and offer tags 1,2,3 back-to-back.
  - Tags 1 and 2 are accepted; in_ready=0 from the cycle after the second accept; tag 3 is held upstream.
  - out_* stay stable at tag 1.
  - Release out_ready -> tags delivered 1,2,3 in order, with no duplication or loss.
- Count=1 with simultaneous push and pop, repeated for 20 cycles with out_ready=1 -> one output per cycle, continuous throughput, ordering intact.
- Flush and reset:
  - With count=2, assert flush with in_valid=1 -> next cycle out_valid=0 and in_ready=1; the flushed-cycle input never appears.
  - Separately, assert rst mid-stream, asynchronously between clock edges -> out_valid drops immediately and all outputs read 0.
